// File: rtl/mdr_mem_port_if.sv
// mdr_mem_port_if: bus, command and memory handshake signals of the memory data register
interface mdr_mem_port_if #(
  parameter int DATA_W = 32
);
  localparam int LANE_W = $clog2(DATA_W / 8);
  logic              MDRin;
  logic              MDRout;
  logic              read;
  logic              write;
  logic [1:0]        size;
  logic              sign;
  logic [LANE_W-1:0] addr_lo;
  logic [DATA_W-1:0] busMuxout;
  logic [DATA_W-1:0] Mdatain;
  logic              mem_ack;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W/8-1:0] mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] bus_out;
  logic              busy;
  logic              done;
  logic              err;
  modport master (
    output MDRin, MDRout, read, write, size, sign, addr_lo, busMuxout, Mdatain, mem_ack,
    input  mem_req, mem_we, mem_be, mem_wdata, q, bus_out, busy, done, err
  );
  modport slave (
    input  MDRin, MDRout, read, write, size, sign, addr_lo, busMuxout, Mdatain, mem_ack,
    output mem_req, mem_we, mem_be, mem_wdata, q, bus_out, busy, done, err
  );
endinterface

// File: rtl/mdr_mem_port.sv
// mdr_mem_port: memory data register with req/ack handshake, timeout and byte-lane load/store
module mdr_mem_port #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic            clk,
  input logic            clr,
  mdr_mem_port_if.slave  bus
);
  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int CW     = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t            r_state;
  logic [DATA_W-1:0] r_q;
  logic              r_err;
  logic              r_done;
  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_size;
  logic              r_sign;
  logic [LANE_W-1:0] r_addr;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ld;
  logic [NB-1:0]     w_lanes;
  logic [DATA_W-1:0] w_wdata;
  logic              w_to;
  // lane extraction and store formatting, all driven by the latched command
  always_comb begin
    w_byte  = 8'(bus.Mdatain >> {r_addr, 3'b000});
    w_half  = 16'(bus.Mdatain >> {r_addr[LANE_W-1:1], 4'b0000});
    w_ld    = r_size[1] ? bus.Mdatain :
              r_size[0] ? {{(DATA_W-16){r_sign & w_half[15]}}, w_half} :
                          {{(DATA_W-8){r_sign & w_byte[7]}}, w_byte};
    w_lanes = r_size[1] ? '1 :
              r_size[0] ? NB'(3) << {r_addr[LANE_W-1:1], 1'b0} :
                          NB'(1) << r_addr;
    w_wdata = r_size[1] ? r_q : r_size[0] ? {(DATA_W/16){r_q[15:0]}} : {NB{r_q[7:0]}};
    w_to    = (TIMEOUT != 0) && (r_cnt == LAST);
  end
  // command acceptance, request tracking, completion and timeout
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_sign  <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.read || bus.write) begin
            r_state <= bus.read ? RD : WR;
            r_size  <= bus.size;
            r_sign  <= bus.sign;
            r_addr  <= bus.addr_lo;
            r_err   <= 1'b0;
            r_cnt   <= '0;
          end else if (bus.MDRin) begin
            r_q <= bus.busMuxout;
          end
        end
        default: begin
          if (bus.mem_ack) begin
            if (r_state == RD) r_q <= w_ld;
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else if (w_to) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end
  assign bus.mem_req   = r_state != IDLE;
  assign bus.busy      = r_state != IDLE;
  assign bus.mem_we    = r_state == WR;
  assign bus.mem_be    = r_state == WR ? w_lanes : '0;
  assign bus.mem_wdata = r_state == WR ? w_wdata : '0;
  assign bus.q         = r_q;
  assign bus.bus_out   = bus.MDRout ? r_q : '0;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_mdr_mem_port.sv
// tb_mdr_mem_port: directed and randomized checks of mdr_mem_port against a lane-arithmetic model
module tb_mdr_mem_port;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [31:0] mq = '0;
  mdr_mem_port_if #(.DATA_W(32)) if_ ();
  mdr_mem_port #(.DATA_W(32), .TIMEOUT(15)) dut (.clk(clk), .clr(clr), .bus(if_));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(logic [31:0] d, logic [1:0] sz, int a, bit s);
    int w = sz[1] ? 32 : sz[0] ? 16 : 8;
    int lo = sz[1] ? 0 : sz[0] ? (a / 2) * 2 : a;
    longint f = (longint'(d) >> (8 * lo)) & ((longint'(1) << w) - 1);
    if (s && w < 32 && f >= (longint'(1) << (w - 1))) f = f - (longint'(1) << w);
    return 32'(f);
  endfunction

  function automatic logic [3:0] exp_be(logic [1:0] sz, int a);
    return sz[1] ? 4'hF : sz[0] ? 4'(3 << ((a / 2) * 2)) : 4'(1 << a);
  endfunction

  function automatic logic [31:0] exp_wdata(logic [31:0] v, logic [1:0] sz);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sz[1] ? v[8*i +: 8] : sz[0] ? v[8*(i%2) +: 8] : v[7:0];
    return r;
  endfunction

  task automatic load(input logic [31:0] v);
    if_.MDRin = 1'b1;
    if_.busMuxout = v;
    tick();
    if_.MDRin = 1'b0;
    mq = v;
    chk("load_q", if_.q, mq);
  endtask

  task automatic do_cmd(input bit wr, input logic [31:0] d, input logic [1:0] sz,
                        input int a, input bit s, input int dly);
    if_.read = !wr;
    if_.write = 1'b1;
    if_.MDRin = 1'b1;
    if_.busMuxout = ~mq;
    if_.size = sz;
    if_.addr_lo = 2'(a);
    if_.sign = s;
    tick();
    if_.read = 1'b0;
    if_.write = 1'b0;
    chk("cmd_err_clr", {31'b0, if_.err}, 32'd0);
    for (int n = 0; n <= dly; n++) begin
      if_.size = 2'($urandom);
      if_.addr_lo = 2'($urandom);
      if_.sign = 1'($urandom);
      if_.MDRin = 1'($urandom);
      if_.busMuxout = $urandom;
      chk("req", {31'b0, if_.mem_req}, 32'd1);
      chk("busy", {31'b0, if_.busy}, 32'd1);
      chk("we", {31'b0, if_.mem_we}, {31'b0, wr});
      chk("be", {28'b0, if_.mem_be}, wr ? {28'b0, exp_be(sz, a)} : 32'd0);
      if (wr) chk("wdata", if_.mem_wdata, exp_wdata(mq, sz));
      chk("q_hold", if_.q, mq);
      if_.mem_ack = (n == dly);
      if_.Mdatain = (n == dly) ? d : $urandom;
      tick();
    end
    if_.mem_ack = 1'b0;
    if_.MDRin = 1'b0;
    if (!wr) mq = exp_load(d, sz, a, s);
    chk("done", {31'b0, if_.done}, 32'd1);
    chk("req_drop", {31'b0, if_.mem_req}, 32'd0);
    chk("q_result", if_.q, mq);
    chk("err_ok", {31'b0, if_.err}, 32'd0);
    tick();
    chk("done_pulse", {31'b0, if_.done}, 32'd0);
  endtask

  initial begin
    int cnt;
    if_.MDRin = 0; if_.MDRout = 0; if_.read = 0; if_.write = 0; if_.size = 0; if_.sign = 0;
    if_.addr_lo = 0; if_.busMuxout = 0; if_.Mdatain = 0; if_.mem_ack = 0;
    tick();
    tick();
    chk("rst_q", if_.q, 32'd0);
    chk("rst_bus_out", if_.bus_out, 32'd0);
    chk("rst_flags", {27'b0, if_.busy, if_.done, if_.err, if_.mem_req, if_.mem_we}, 32'd0);
    chk("rst_be", {28'b0, if_.mem_be}, 32'd0);
    chk("rst_wdata", if_.mem_wdata, 32'd0);
    clr = 1'b0;
    load(32'hDEADBEEF);
    chk("bus_out_off", if_.bus_out, 32'd0);
    if_.MDRout = 1'b1;
    #1;
    chk("bus_out_on", if_.bus_out, 32'hDEADBEEF);
    if_.MDRout = 1'b0;
    do_cmd(0, 32'h12345678, 2'b10, 0, 0, 2);
    chk("word_read", mq, 32'h12345678);
    do_cmd(0, 32'h80FF7F01, 2'b00, 2, 1, 1);
    chk("byte_sx", mq, 32'hFFFFFFFF);
    do_cmd(0, 32'h80FF7F01, 2'b00, 1, 0, 0);
    chk("byte_zx", mq, 32'h0000007F);
    do_cmd(0, 32'h80FF7F01, 2'b01, 2, 1, 3);
    chk("half_sx", mq, 32'hFFFF80FF);
    load(32'h000000A5);
    do_cmd(1, 32'h0, 2'b00, 3, 0, 2);
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) load($urandom);
      do_cmd(1'($urandom), $urandom, 2'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
             int'($urandom_range(0, 5)));
    end
    if_.read = 1'b1;
    if_.size = 2'b10;
    tick();
    if_.read = 1'b0;
    cnt = 0;
    while (if_.mem_req && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("timeout_cycles", cnt, 32'd15);
    chk("timeout_err", {31'b0, if_.err}, 32'd1);
    chk("timeout_nodone", {31'b0, if_.done}, 32'd0);
    chk("timeout_q", if_.q, mq);
    tick();
    chk("err_sticky", {31'b0, if_.err}, 32'd1);
    do_cmd(0, 32'hCAFEF00D, 2'b10, 0, 0, 14);
    load(32'h5A5A1234);
    if_.write = 1'b1;
    if_.size = 2'b10;
    tick();
    if_.write = 1'b0;
    chk("wr_req", {31'b0, if_.mem_req}, 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    mq = '0;
    chk("clr_req", {31'b0, if_.mem_req}, 32'd0);
    chk("clr_q", if_.q, mq);
    if_.mem_ack = 1'b1;
    tick();
    if_.mem_ack = 1'b0;
    chk("clr_ack_nodone", {31'b0, if_.done}, 32'd0);
    chk("clr_ack_q", if_.q, mq);
    chk("clr_ack_req", {31'b0, if_.mem_req}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mdr_mem_port.md
# mdr_mem_port

Parametrised memory data register for the Mini SRC datapath with a built-in memory handshake. It holds the data word exchanged between the internal bus and memory. It issues read/write requests with a req/ack protocol and a timeout. It performs byte/halfword lane selection, with sign or zero extension on loads. It sits between the bus multiplexer and the memory port, replacing the fixed-width, handshake-free MDR.

## Interface
- DATA_W, 32, data width; multiple of 16, ≥32
- TIMEOUT, 15, max cycles a request is held waiting for ack; 0 disables the timeout
- LANE_W (derived), $clog2(DATA_W/8), width of addr_lo

Ports:
- clk  in  1  clock, all state updates on rising edge
- clr  in  1  synchronous, active-high reset
- MDRin  in  1  load q from busMuxout (idle only)
- MDRout  in  1  drive q onto bus_out
- read  in  1  start memory read (idle only)
- write  in  1  start memory write of q (idle only)
- size  in  2  00 byte, 01 halfword, 10/11 full width
- sign  in  1  1 = sign-extend sub-word loads, 0 = zero-extend
- addr_lo  in  LANE_W  low address bits selecting the byte lane
- busMuxout  in  DATA_W  bus data
- Mdatain  in  DATA_W  memory read data
- mem_ack  in  1  memory completion, one cycle
- mem_req  out  1  memory request
- mem_we  out  1  1 = write request
- mem_be  out  DATA_W/8  byte enables
- mem_wdata  out  DATA_W  write data
- q  out  DATA_W  register contents
- bus_out  out  DATA_W  MDRout ? q : 0 (combinational)
- busy  out  1  request in flight
- done  out  1  one-cycle pulse after successful completion
- err  out  1  timeout flag

## Operation
- FSM states: IDLE, RD, WR.
- In IDLE:
  - read=1 → RD.
  - Else write=1 → WR.
  - Else MDRin=1 → q ← busMuxout.
  - Priority is read > write > MDRin. Lower-priority inputs in the same cycle are ignored.
- Command start:
  - Latches size, sign and addr_lo into command registers. Later changes to these inputs have no effect until IDLE.
  - Clears err and the timeout counter.
- RD/WR:
  - mem_req=1 and busy=1; mem_we=1 in WR only. All three are decoded from state register, so they assert the cycle after the command.
  - MDRin, read and write are ignored while busy.
- Lane selection uses the latched addr_lo. Byte: lane addr_lo. Half: lanes {addr_lo[LANE_W-1:1],0} and +1. Full: all lanes.
- RD completion, on the edge with mem_ack=1:
  - q ← selected lanes of Mdatain, right-justified.
  - Upper bits are filled with the sign bit of the selected field (sign=1) or 0.
  - Full width loads copy Mdatain.
  - → IDLE, done=1 next cycle.
- WR:
  - mem_be is the selected lanes (all ones for full); 0 outside WR.
  - mem_wdata is q[7:0] replicated across all lanes (byte), q[15:0] replicated (half), or q (full).
  - On the mem_ack edge → IDLE, done pulse; q unchanged.
- Timeout (TIMEOUT>0):
  - The counter increments every RD/WR cycle without ack.
  - On the edge where there is no ack and counter==TIMEOUT-1, the request has been held exactly TIMEOUT cycles: → IDLE, err=1, no done, q unchanged.
  - An ack in that same cycle wins: normal completion, no err.
- err stays high until clr or the next command start.
- mem_ack in IDLE is ignored.
- clr (any state, overrides everything):
  - State IDLE; q, err, done and counter set to 0.
  - mem_req drops in the cycle following the clr edge.

## Timing
- Reset values: q=0, bus_out=0, busy=0, done=0, err=0, mem_req=0, mem_we=0, mem_be=0, mem_wdata=0.
- MDRin load: q visible 1 cycle after the enabling edge.
- Read with ack N cycles after mem_req rises (N≥0, ack in first req cycle = N=0):
  - q updated at the ack edge.
  - done high the following cycle.
  - A new command is accepted in the done cycle.
- Minimum transaction: command cycle + 1 req cycle; done in cycle 3.
- done is exactly one cycle. busy and mem_req are identical.
- A read/write asserted in the done cycle starts immediately (back-to-back).

## Test plan
- Reset/load: clr=1, then MDRin=1, busMuxout=0xDEADBEEF → all outputs 0 after clr; q=0xDEADBEEF next cycle; with MDRout=1, bus_out=0xDEADBEEF, else 0.
- Word read: read=1, size=10, mem_ack 2 cycles after req rises, Mdatain=0x12345678 → mem_req high 3 cycles, q=0x12345678, one-cycle done, mem_we=0 throughout.
- Sub-word reads with Mdatain=0x80FF7F01:
  - size=00, addr_lo=2, sign=1 → q=0xFFFFFFFF.
  - addr_lo=1, sign=0 → q=0x0000007F.
  - size=01, addr_lo=2, sign=1 → q=0xFFFF80FF.
- Byte write: q=0x000000A5, write=1, size=00, addr_lo=3 → mem_we=1, mem_be=4'b1000, mem_wdata=0xA5A5A5A5 until ack; q unchanged.
- Timeout: TIMEOUT=15, read, no ack → mem_req high exactly 15 cycles, then err=1, no done, q unchanged. Next read clears err. Ack in the 15th cycle → done, err=0.
- Conflicts/reset: read+write+MDRin together → read performed, q not loaded from bus. MDRin during RD → ignored. clr during WR → mem_req low next cycle, q=0, later ack ignored.
